// File: rtl/print_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | print_pkg: print-line geometry and shifter FSM state encoding.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package print_pkg;

    localparam int DOTS_PER_LINE   = 384;
    localparam int BYTES_PER_LINE  = 48;
    localparam int DOTS_PER_GROUP  = 64;
    localparam int GROUPS_PER_LINE = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_LOW   = 3'd3,
        ST_HIGH  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage : print_pkg
`default_nettype wire

// File: rtl/print_bit_clock.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | print_bit_clock: CLK_DIV half-period divider producing CLKimpr level. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module print_bit_clock #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic half_done_o,
    output logic clkimpr_o
);

    localparam int             CW       = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0]  C_LAST   = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic          lvl_q;

    assign half_done_o = en_i && (cnt_q == C_LAST);
    assign clkimpr_o   = lvl_q;

    // Dropping enable parks the clock low so every new LOW phase starts aligned.
    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            cnt_q <= '0;
            lvl_q <= 1'b0;
        end else if (cnt_q == C_LAST) begin
            cnt_q <= '0;
            lvl_q <= ~lvl_q;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule : print_bit_clock
`default_nettype wire

// File: rtl/print_line_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | print_line_shifter: fetches a print line byte-wise, shifts it MSB     |
// | first onto DO with the CLKimpr head clock. Rev 1.0                    |
// +----------------------------------------------------------------------+
module print_line_shifter
    import print_pkg::*;
#(
    parameter int DOTS    = DOTS_PER_LINE,
    parameter int CLK_DIV = 4,
    parameter int ADDR_W  = 6
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              line_valid,
    output logic              line_ack,
    output logic              busy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    input  logic              stb_busy,
    output logic              CLKimpr,
    output logic              DO
);

    localparam logic [ADDR_W-1:0] C_LAST_BYTE = ADDR_W'(DOTS / 8 - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] byte_q;
    logic [2:0]        bit_q;
    logic [7:0]        sr_q;
    logic              do_q;
    logic              ack_q;
    logic              rd_en_q;
    logic              bit_en;
    logic              half_done;

    assign bit_en   = (state_q == ST_LOW) || (state_q == ST_HIGH);
    assign busy     = (state_q != ST_IDLE);
    assign line_ack = ack_q;
    assign rd_en    = rd_en_q;
    assign rd_addr  = byte_q;
    assign DO       = do_q;

    print_bit_clock #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_clock (
        .clk_i       (CLK),
        .rst_i       (RST),
        .en_i        (bit_en),
        .half_done_o (half_done),
        .clkimpr_o   (CLKimpr)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            byte_q  <= '0;
            bit_q   <= 3'd0;
            sr_q    <= 8'd0;
            do_q    <= 1'b0;
            ack_q   <= 1'b0;
            rd_en_q <= 1'b0;
        end else begin
            ack_q   <= 1'b0;
            rd_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (line_valid && !stb_busy) begin
                        state_q <= ST_FETCH;
                        rd_en_q <= 1'b1;
                    end
                end
                ST_FETCH: state_q <= ST_LOAD;
                ST_LOAD: begin
                    // rd_data is valid now, one cycle after the FETCH strobe.
                    sr_q    <= rd_data;
                    do_q    <= rd_data[7];
                    bit_q   <= 3'd7;
                    state_q <= ST_LOW;
                end
                ST_LOW: begin
                    if (half_done) begin
                        state_q <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (half_done) begin
                        if (bit_q != 3'd0) begin
                            bit_q   <= bit_q - 3'd1;
                            do_q    <= sr_q[bit_q - 3'd1];
                            state_q <= ST_LOW;
                        end else if (byte_q != C_LAST_BYTE) begin
                            byte_q  <= byte_q + ADDR_W'(1);
                            rd_en_q <= 1'b1;
                            state_q <= ST_FETCH;
                        end else begin
                            byte_q  <= '0;
                            do_q    <= 1'b0;
                            ack_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule : print_line_shifter
`default_nettype wire

// File: tb/tb_print_line_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_print_line_shifter: randomized line checks against a dot model.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_print_line_shifter;

    logic       CLK = 1'b0;
    logic       RST;
    logic       line_valid, stb_busy;
    logic       line_ack, busy, rd_en, CLKimpr, DO;
    logic [5:0] rd_addr;
    logic [7:0] rd_data = 8'd0;

    logic       lv1, stb1;
    logic       ack1, busy1, rden1, clk1, do1;
    logic [5:0] addr1;
    logic [7:0] rdata1 = 8'd0;

    logic [7:0] mem  [64];
    logic [7:0] mem1 [64];

    int checks = 0;
    int errors = 0;

    bit q_dots  [$];
    bit q_dots1 [$];
    int q_addr  [$];
    int q_rdcyc [$];
    int q_ackcyc[$];
    int cyc = 0, high_cnt = 0, high1 = 0, acks = 0;
    logic prev_clk = 1'b0, prev_clk1 = 1'b0;

    print_line_shifter #(.DOTS(384), .CLK_DIV(4), .ADDR_W(6)) dut (
        .CLK(CLK), .RST(RST), .line_valid(line_valid), .line_ack(line_ack),
        .busy(busy), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .stb_busy(stb_busy), .CLKimpr(CLKimpr), .DO(DO)
    );

    print_line_shifter #(.DOTS(384), .CLK_DIV(1), .ADDR_W(6)) dut1 (
        .CLK(CLK), .RST(RST), .line_valid(lv1), .line_ack(ack1),
        .busy(busy1), .rd_en(rden1), .rd_addr(addr1), .rd_data(rdata1),
        .stb_busy(stb1), .CLKimpr(clk1), .DO(do1)
    );

    always #5 CLK = ~CLK;

    // Synchronous line buffers: data one cycle after the read strobe.
    always @(posedge CLK) begin
        if (rd_en) rd_data <= mem[rd_addr];
        if (rden1) rdata1  <= mem1[addr1];
    end

    always @(negedge CLK) begin
        cyc++;
        if (CLKimpr && !prev_clk) q_dots.push_back(DO);
        if (clk1 && !prev_clk1) q_dots1.push_back(do1);
        if (CLKimpr) high_cnt++;
        if (clk1) high1++;
        prev_clk  = CLKimpr;
        prev_clk1 = clk1;
        if (rd_en) begin
            q_addr.push_back(int'(rd_addr));
            q_rdcyc.push_back(cyc);
        end
        if (line_ack) begin
            acks++;
            q_ackcyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Dot n of a line is bit 7-(n mod 8) of byte n/8; count deviations.
    function automatic int line_errs(input bit q[$], input logic [7:0] m[64], input int off);
        int e = 0;
        for (int n = 0; n < 384; n++) begin
            if (off + n >= q.size()) e++;
            else if (q[off + n] !== m[n / 8][7 - (n % 8)]) e++;
        end
        return e;
    endfunction

    task automatic clear_mon();
        q_dots.delete(); q_dots1.delete(); q_addr.delete();
        q_rdcyc.delete(); q_ackcyc.delete();
        high_cnt = 0; high1 = 0;
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!line_ack && n < 5000);
    endtask

    task automatic fill_random();
        for (int k = 0; k < 64; k++) mem[k] = 8'($urandom);
    endtask

    initial begin
        int  n, a0, bsy_seen;
        RST = 1'b1; line_valid = 1'b0; stb_busy = 1'b0; lv1 = 1'b0; stb1 = 1'b0;
        for (int k = 0; k < 64; k++) begin mem[k] = 8'd0; mem1[k] = 8'd0; end
        repeat (3) @(negedge CLK);
        check("rst_clkimpr", 32'(CLKimpr), 0);
        check("rst_do", 32'(DO), 0);
        check("rst_ack", 32'(line_ack), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rd_en", 32'(rd_en), 0);
        check("rst_rd_addr", 32'(rd_addr), 0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        // Single-dot corner pattern with latency and clock-count checks.
        mem[0] = 8'h80; mem[47] = 8'h01;
        clear_mon();
        line_valid = 1'b1;
        wait_ack(n);
        line_valid = 1'b0;
        check("latency_div4", 32'(n), 3169);
        repeat (3) @(negedge CLK);
        check("rises_a", 32'(q_dots.size()), 384);
        check("dot0_a", 32'(q_dots.size() > 0 ? q_dots[0] : 1'bx), 1);
        check("dot383_a", 32'(q_dots.size() > 383 ? q_dots[383] : 1'bx), 1);
        check("dots_a", 32'(line_errs(q_dots, mem, 0)), 0);
        check("high_cycles_a", 32'(high_cnt), 384 * 4);

        // Byte k = k: dot stream and read address sequence.
        for (int k = 0; k < 64; k++) mem[k] = 8'(k);
        clear_mon();
        line_valid = 1'b1;
        wait_ack(n);
        line_valid = 1'b0;
        repeat (3) @(negedge CLK);
        check("dots_b", 32'(line_errs(q_dots, mem, 0)), 0);
        check("rd_count_b", 32'(q_addr.size()), 48);
        a0 = 0;
        for (int k = 0; k < 48; k++) if (k >= q_addr.size() || q_addr[k] != k) a0++;
        check("rd_addr_seq_b", 32'(a0), 0);

        for (int r = 0; r < 3; r++) begin
            fill_random();
            clear_mon();
            line_valid = 1'b1;
            wait_ack(n);
            line_valid = 1'b0;
            repeat (3) @(negedge CLK);
            check("latency_rand", 32'(n), 3169);
            check("dots_rand", 32'(line_errs(q_dots, mem, 0)), 0);
        end

        // Strobe hold-off, then release; strobe mid-line must not disturb it.
        fill_random();
        clear_mon();
        stb_busy = 1'b1; line_valid = 1'b1; bsy_seen = 0;
        repeat (500) begin
            @(negedge CLK);
            if (busy !== 1'b0) bsy_seen++;
        end
        check("stb_hold_busy", 32'(bsy_seen), 0);
        check("stb_hold_rd", 32'(q_addr.size()), 0);
        check("stb_hold_rises", 32'(q_dots.size()), 0);
        stb_busy = 1'b0;
        @(negedge CLK);
        check("stb_release_busy", 32'(busy), 1);
        check("stb_release_rd_en", 32'(rd_en), 1);
        repeat (200) @(negedge CLK);
        stb_busy = 1'b1;
        wait_ack(n);
        line_valid = 1'b0;
        stb_busy = 1'b0;
        repeat (3) @(negedge CLK);
        check("dots_stb", 32'(line_errs(q_dots, mem, 0)), 0);

        // Reset abort at dot 100 followed by a fresh full line.
        fill_random();
        clear_mon();
        line_valid = 1'b1;
        n = 0;
        while (q_dots.size() < 101 && n < 5000) begin @(negedge CLK); n++; end
        a0 = acks;
        RST = 1'b1;
        @(negedge CLK);
        check("abort_clkimpr", 32'(CLKimpr), 0);
        check("abort_do", 32'(DO), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_ack", 32'(line_ack), 0);
        RST = 1'b0;
        clear_mon();
        wait_ack(n);
        line_valid = 1'b0;
        repeat (3) @(negedge CLK);
        check("abort_one_ack", 32'(acks - a0), 1);
        check("dots_after_abort", 32'(line_errs(q_dots, mem, 0)), 0);

        // line_valid held across two lines.
        fill_random();
        clear_mon();
        line_valid = 1'b1;
        wait_ack(n);
        wait_ack(n);
        line_valid = 1'b0;
        repeat (3) @(negedge CLK);
        check("two_acks", 32'(q_ackcyc.size()), 2);
        check("two_rd_count", 32'(q_addr.size()), 96);
        if (q_ackcyc.size() >= 1 && q_rdcyc.size() >= 49) begin
            check("ack_before_next_line", 32'(q_rdcyc[47] < q_ackcyc[0]), 1);
            check("next_fetch_gap", 32'(q_rdcyc[48] - q_ackcyc[0]), 2);
        end else begin
            check("two_line_events", 32'(q_rdcyc.size()), 96);
        end
        check("dots_line1", 32'(line_errs(q_dots, mem, 0)), 0);
        check("dots_line2", 32'(line_errs(q_dots, mem, 384)), 0);

        // CLK_DIV = 1 instance.
        for (int k = 0; k < 64; k++) mem1[k] = 8'($urandom);
        clear_mon();
        lv1 = 1'b1;
        n = 0;
        do begin @(negedge CLK); n++; end while (!ack1 && n < 5000);
        lv1 = 1'b0;
        repeat (3) @(negedge CLK);
        check("latency_div1", 32'(n), 865);
        check("rises_div1", 32'(q_dots1.size()), 384);
        check("high_cycles_div1", 32'(high1), 384);
        check("dots_div1", 32'(line_errs(q_dots1, mem1, 0)), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_print_line_shifter
`default_nettype wire
